// File: rtl/onehot_pkg.sv
// Shared definitions for select-vector checkers: class encodings and a
// constant-time ceil(log2) helper for sizing index fields.
package onehot_pkg;

  typedef logic [1:0] cls_t;

  localparam cls_t CLS_ZERO  = 2'd0;
  localparam cls_t CLS_ONE   = 2'd1;
  localparam cls_t CLS_MULTI = 2'd2;

  // Returns ceil(log2(v)), with a minimum of 1 so a 2-line select still gets a real index bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << r) < v) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_classify.sv
// Combinational zero / one-hot / multi-hot classifier for an N-bit select,
// built as a ripple seen-one / seen-two chain from LSB to MSB.
module onehot_classify
  import onehot_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     sel_i,
  output cls_t             cls_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             seen_one;
  logic             seen_two;
  logic [IDX_W-1:0] first_idx;

  always_comb begin
    seen_one  = 1'b0;
    seen_two  = 1'b0;
    first_idx = '0;
    for (int i = 0; i < N; i++) begin
      // A set bit arriving after another set bit promotes the chain to "seen two".
      seen_two  = seen_two | (seen_one & sel_i[i]);
      first_idx = first_idx | ({IDX_W{sel_i[i] & ~seen_one}} & IDX_W'(i));
      seen_one  = seen_one | sel_i[i];
    end
  end

  always_comb begin
    cls_o = CLS_ONE;
    idx_o = '0;
    if (!seen_one) begin
      cls_o = CLS_ZERO;
    end else if (seen_two) begin
      cls_o = CLS_MULTI;
    end else begin
      idx_o = first_idx;
    end
  end

endmodule

// File: rtl/onehot_sel_monitor.sv
// Two-stage select-pattern monitor: registers the select, classifies it and
// tracks illegal (zero / multi-hot) patterns with a sticky flag and saturating count.
module onehot_sel_monitor
  import onehot_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int CNT_W = 8,
  localparam int IDX_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     sel,
  input  logic             clr_err,
  output logic             out_valid,
  output logic             onehot,
  output logic             zero,
  output logic             multi,
  output logic [IDX_W-1:0] idx,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  logic             s1_v_q;
  logic [N-1:0]     s1_sel_q;
  logic             out_valid_q;
  logic             onehot_q;
  logic             zero_q;
  logic             multi_q;
  logic [IDX_W-1:0] idx_q;
  logic             err_sticky_q;
  logic             err_sticky_d;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;
  logic [CNT_W-1:0] cnt_base;

  cls_t             cls;
  logic [IDX_W-1:0] cls_idx;
  logic             err_event;

  onehot_classify #(.N(N)) u_classify (
    .sel_i (s1_sel_q),
    .cls_o (cls),
    .idx_o (cls_idx)
  );

  // Clear acts first so a same-cycle error still leaves a count of one.
  always_comb begin
    err_event    = s1_v_q & (cls != CLS_ONE);
    cnt_base     = clr_err ? '0 : err_cnt_q;
    err_cnt_d    = cnt_base;
    if (err_event && (cnt_base != {CNT_W{1'b1}})) begin
      err_cnt_d = cnt_base + CNT_W'(1);
    end
    err_sticky_d = (err_sticky_q & ~clr_err) | err_event;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q       <= 1'b0;
      s1_sel_q     <= '0;
      out_valid_q  <= 1'b0;
      onehot_q     <= 1'b0;
      zero_q       <= 1'b0;
      multi_q      <= 1'b0;
      idx_q        <= '0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      s1_v_q      <= in_valid;
      if (in_valid) begin
        s1_sel_q <= sel;
      end
      out_valid_q <= s1_v_q;
      if (s1_v_q) begin
        onehot_q <= (cls == CLS_ONE);
        zero_q   <= (cls == CLS_ZERO);
        multi_q  <= (cls == CLS_MULTI);
        idx_q    <= cls_idx;
      end
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign onehot     = onehot_q;
  assign zero       = zero_q;
  assign multi      = multi_q;
  assign idx        = idx_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_onehot_sel_monitor.sv
// Directed bench for onehot_sel_monitor: default config, a narrow-counter
// config for saturation, and an 8-line config swept over every select value.
module tb_onehot_sel_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: N=4, CNT_W=8
  logic       a_iv = 1'b0, a_clr = 1'b0;
  logic [3:0] a_sel = '0;
  logic       a_ov, a_one, a_zero, a_multi, a_sticky;
  logic [1:0] a_idx;
  logic [7:0] a_cnt;

  // Instance B: N=4, CNT_W=2
  logic       b_iv = 1'b0, b_clr = 1'b0;
  logic [3:0] b_sel = '0;
  logic       b_ov, b_one, b_zero, b_multi, b_sticky;
  logic [1:0] b_idx;
  logic [1:0] b_cnt;

  // Instance C: N=8, CNT_W=8
  logic       c_iv = 1'b0, c_clr = 1'b0;
  logic [7:0] c_sel = '0;
  logic       c_ov, c_one, c_zero, c_multi, c_sticky;
  logic [2:0] c_idx;
  logic [7:0] c_cnt;

  onehot_sel_monitor #(.N(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .sel(a_sel), .clr_err(a_clr),
    .out_valid(a_ov), .onehot(a_one), .zero(a_zero), .multi(a_multi),
    .idx(a_idx), .err_sticky(a_sticky), .err_cnt(a_cnt));

  onehot_sel_monitor #(.N(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .sel(b_sel), .clr_err(b_clr),
    .out_valid(b_ov), .onehot(b_one), .zero(b_zero), .multi(b_multi),
    .idx(b_idx), .err_sticky(b_sticky), .err_cnt(b_cnt));

  onehot_sel_monitor #(.N(8), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .sel(c_sel), .clr_err(c_clr),
    .out_valid(c_ov), .onehot(c_one), .zero(c_zero), .multi(c_multi),
    .idx(c_idx), .err_sticky(c_sticky), .err_cnt(c_cnt));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic ov, input logic one, input logic zr,
                       input logic mu, input logic [1:0] ix, input logic st, input logic [7:0] cn);
    chk({tag, ".out_valid"}, 32'(a_ov), 32'(ov));
    chk({tag, ".onehot"}, 32'(a_one), 32'(one));
    chk({tag, ".zero"}, 32'(a_zero), 32'(zr));
    chk({tag, ".multi"}, 32'(a_multi), 32'(mu));
    chk({tag, ".idx"}, 32'(a_idx), 32'(ix));
    chk({tag, ".err_sticky"}, 32'(a_sticky), 32'(st));
    chk({tag, ".err_cnt"}, 32'(a_cnt), 32'(cn));
  endtask

  logic [3:0] t2_sel [4] = '{4'b0001, 4'b0000, 4'b0110, 4'b1000};
  logic       t2_one [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic       t2_zr  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic       t2_mu  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0] t2_idx [4] = '{2'd0, 2'd0, 2'd0, 2'd3};
  logic [7:0] t2_cnt [4] = '{8'd0, 8'd1, 8'd2, 8'd2};
  logic       t2_st  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int errs;
    int pc;
    int pos;
    int v;

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_a("reset", 0, 0, 0, 0, 2'd0, 0, 8'd0);
    chk("reset.b_cnt", 32'(b_cnt), 32'd0);
    chk("reset.c_ov", 32'(c_ov), 32'd0);

    // Single one-hot sample, exact 2-cycle latency, then hold
    a_iv = 1'b1; a_sel = 4'b0100;
    step();
    a_iv = 1'b0; a_sel = 4'b0000;
    chk("t1.latency1", 32'(a_ov), 32'd0);
    step();
    chk_a("t1.result", 1, 1, 0, 0, 2'd2, 0, 8'd0);
    step();
    chk_a("t1.hold", 0, 1, 0, 0, 2'd2, 0, 8'd0);

    // Back-to-back one/zero/multi/one
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        a_iv = 1'b1; a_sel = t2_sel[k];
      end else begin
        a_iv = 1'b0; a_sel = 4'b0000;
      end
      step();
      if (k >= 1) begin
        chk_a($sformatf("t2.v%0d", k-1), 1, t2_one[k-1], t2_zr[k-1], t2_mu[k-1],
              t2_idx[k-1], t2_st[k-1], t2_cnt[k-1]);
      end
    end
    step();
    chk("t2.gap_ov", 32'(a_ov), 32'd0);

    // clr_err coinciding with a multi result, then clr_err alone
    a_iv = 1'b1; a_sel = 4'b1111;
    step();
    a_iv = 1'b0; a_sel = 4'b0000; a_clr = 1'b1;
    step();
    chk_a("t4.clr_event", 1, 0, 0, 1, 2'd0, 1, 8'd1);
    step();
    a_clr = 1'b0;
    chk_a("t4.clr_only", 0, 0, 0, 1, 2'd0, 0, 8'd0);

    // Reset one cycle after accepting a multi-hot sample flushes it
    a_iv = 1'b1; a_sel = 4'b0011;
    step();
    a_iv = 1'b0; a_sel = 4'b0000; rst = 1'b1;
    step();
    rst = 1'b0;
    chk_a("t5.after_rst", 0, 0, 0, 0, 2'd0, 0, 8'd0);
    step();
    chk_a("t5.no_ov1", 0, 0, 0, 0, 2'd0, 0, 8'd0);
    step();
    chk_a("t5.no_ov2", 0, 0, 0, 0, 2'd0, 0, 8'd0);

    // Counter saturation with CNT_W=2
    for (int k = 1; k <= 7; k++) begin
      b_iv  = (k <= 5);
      b_sel = 4'b0000;
      step();
      if (k >= 2) begin
        v = (k - 1 > 5) ? 5 : k - 1;
        if (v > 3) v = 3;
        chk($sformatf("t3.cnt%0d", k), 32'(b_cnt), 32'(v));
      end
    end
    chk("t3.sticky", 32'(b_sticky), 32'd1);
    chk("t3.zero", 32'(b_zero), 32'd1);
    chk("t3.ov_end", 32'(b_ov), 32'd0);

    // Full sweep of an 8-line select
    errs = 0;
    for (int k = 0; k <= 256; k++) begin
      if (k < 256) begin
        c_iv = 1'b1; c_sel = 8'(k);
      end else begin
        c_iv = 1'b0; c_sel = 8'd0;
      end
      step();
      if (k >= 1) begin
        v   = k - 1;
        pc  = 0;
        pos = 0;
        for (int b = 0; b < 8; b++) begin
          if (v[b]) begin
            pc++;
            pos = b;
          end
        end
        if (pc != 1) errs++;
        chk($sformatf("t6.ov.%0d", v), 32'(c_ov), 32'd1);
        chk($sformatf("t6.onehot.%0d", v), 32'(c_one), 32'(pc == 1));
        chk($sformatf("t6.zero.%0d", v), 32'(c_zero), 32'(pc == 0));
        chk($sformatf("t6.multi.%0d", v), 32'(c_multi), 32'(pc >= 2));
        chk($sformatf("t6.idx.%0d", v), 32'(c_idx), (pc == 1) ? 32'(pos) : 32'd0);
        chk($sformatf("t6.cnt.%0d", v), 32'(c_cnt), 32'((errs > 255) ? 255 : errs));
      end
    end
    chk("t6.final_cnt", 32'(c_cnt), 32'd248);
    chk("t6.sticky", 32'(c_sticky), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
